// File: rtl/vga_scan_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_scan_timing_gen
//
// Purpose:
//   Parametrised VGA scan generator. Divides the board clock down to a pixel
//   enable, runs the horizontal/vertical position counters and produces the
//   sync pulses, the visible-window flag, pixel coordinates, line/frame start
//   strobes and a slowly advancing scroll offset for animated scene layers.
//   Sits between the board clock and every scene renderer.
//
// Ports:
//   i_clk           board clock
//   i_rst           synchronous reset, active high (wins over i_enable)
//   i_enable        1 = scan runs, 0 = everything frozen in place
//   i_scrollEn      1 = scroll offset advances on its frame steps
//   o_pixCe         one-clock pixel enable, every CLK_DIV clocks
//   o_hsync         horizontal sync, asserted level given by SYNC_POL
//   o_vsync         vertical sync, asserted level given by SYNC_POL
//   o_active        1 inside the visible H_ACTIVE x V_ACTIVE window
//   o_x, o_y        pixel column/row inside the window, 0 outside it
//   o_lineStart     one-clock strobe when the decode shows column 0
//   o_frameStart    one-clock strobe when the decode shows (0,0)
//   o_scrollOffset  animation offset, 0..SCROLL_MAX-1, wraps
// ---------------------------------------------------------------------------
module vga_scan_timing_gen #(
  parameter int CLK_DIV       = 2,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 29,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int SYNC_POL      = 0,
  parameter int CNT_W         = 11,
  parameter int SCROLL_FRAMES = 1,
  parameter int SCROLL_MAX    = 640
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_scrollEn,
  output logic             o_pixCe,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_active,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_lineStart,
  output logic             o_frameStart,
  output logic [CNT_W-1:0] o_scrollOffset
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FRM_W   = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST    = FRM_W'(SCROLL_FRAMES - 1);
  localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_END  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_END  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_BEG   = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] V_ACT_BEG   = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] H_ACT_END   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [CNT_W-1:0] SCROLL_LAST = CNT_W'(SCROLL_MAX - 1);
  localparam logic             SYNC_ON     = (SYNC_POL != 0);

  logic [DIV_W-1:0] r_divCnt;
  logic [CNT_W-1:0] r_hCnt;
  logic [CNT_W-1:0] r_vCnt;
  logic [FRM_W-1:0] r_frmCnt;
  logic             r_decodePending;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_active;
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             r_lineStart;
  logic             r_frameStart;
  logic [CNT_W-1:0] r_scrollOffset;

  logic             w_pixCe;
  logic             w_hSyncOn;
  logic             w_vSyncOn;
  logic             w_hActive;
  logic             w_vActive;
  logic [CNT_W-1:0] w_xCalc;
  logic [CNT_W-1:0] w_yCalc;
  logic             w_lineHome;
  logic             w_frameHome;
  logic             w_frameStep;

  // Pixel enable is a pure decode of the divider so it drops to 0 in the very
  // clock enable goes low; reset also masks it so it reads 0 while held.
  assign w_pixCe = i_enable & ~i_rst & (r_divCnt == DIV_LAST);

  // Clock divider: free-running 0..CLK_DIV-1 while enabled, holds otherwise.
  // With CLK_DIV=1 it sits at 0 and the pixel enable follows i_enable.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_divCnt <= '0;
    end else if (i_enable) begin
      r_divCnt <= (r_divCnt == DIV_LAST) ? '0 : r_divCnt + DIV_W'(1);
    end
  end

  // Raster position counters, stepped once per pixel. The vertical counter
  // steps only on the horizontal wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hCnt <= '0;
      r_vCnt <= '0;
    end else if (w_pixCe) begin
      if (r_hCnt == H_LAST) begin
        r_hCnt <= '0;
        r_vCnt <= (r_vCnt == V_LAST) ? '0 : r_vCnt + CNT_W'(1);
      end else begin
        r_hCnt <= r_hCnt + CNT_W'(1);
      end
    end
  end

  // Marks that the counters moved on the previous enabled edge, so the output
  // decode refreshes exactly once per pixel. It comes out of reset set so the
  // (0,0) position is decoded and the first frame after reset pulses too.
  // It holds while disabled so a resume picks up an update still owed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_decodePending <= 1'b1;
    end else if (i_enable) begin
      r_decodePending <= w_pixCe;
    end
  end

  assign w_hSyncOn   = (r_hCnt < H_SYNC_END);
  assign w_vSyncOn   = (r_vCnt < V_SYNC_END);
  assign w_hActive   = (r_hCnt >= H_ACT_BEG) && (r_hCnt < H_ACT_END);
  assign w_vActive   = (r_vCnt >= V_ACT_BEG) && (r_vCnt < V_ACT_END);
  assign w_xCalc     = r_hCnt - H_ACT_BEG;
  assign w_yCalc     = r_vCnt - V_ACT_BEG;
  assign w_lineHome  = (r_hCnt == '0);
  assign w_frameHome = w_lineHome && (r_vCnt == '0);
  assign w_frameStep = i_enable && r_decodePending && w_frameHome;

  // Registered output decode. Levels refresh only on the clock after the
  // counters moved; the strobes are cleared on every other enabled clock and
  // forced low while disabled, so a held position never re-fires them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hsync      <= ~SYNC_ON;
      r_vsync      <= ~SYNC_ON;
      r_active     <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_lineStart  <= 1'b0;
      r_frameStart <= 1'b0;
    end else if (!i_enable) begin
      r_lineStart  <= 1'b0;
      r_frameStart <= 1'b0;
    end else if (r_decodePending) begin
      r_hsync      <= w_hSyncOn ? SYNC_ON : ~SYNC_ON;
      r_vsync      <= w_vSyncOn ? SYNC_ON : ~SYNC_ON;
      r_active     <= w_hActive && w_vActive;
      r_x          <= (w_hActive && w_vActive) ? w_xCalc : '0;
      r_y          <= (w_hActive && w_vActive) ? w_yCalc : '0;
      r_lineStart  <= w_lineHome;
      r_frameStart <= w_frameHome;
    end else begin
      r_lineStart  <= 1'b0;
      r_frameStart <= 1'b0;
    end
  end

  // Scroll animation: the frame counter ticks on the same edge that raises the
  // frame strobe; each time it completes SCROLL_FRAMES frames it clears and,
  // if scrolling is allowed, the offset steps and wraps. With scrolling off
  // the frame counter keeps running so the cadence stays aligned.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frmCnt       <= '0;
      r_scrollOffset <= '0;
    end else if (w_frameStep) begin
      if (r_frmCnt == FRM_LAST) begin
        r_frmCnt <= '0;
        if (i_scrollEn) begin
          r_scrollOffset <= (r_scrollOffset == SCROLL_LAST) ? '0
                                                            : r_scrollOffset + CNT_W'(1);
        end
      end else begin
        r_frmCnt <= r_frmCnt + FRM_W'(1);
      end
    end
  end

  assign o_pixCe        = w_pixCe;
  assign o_hsync        = r_hsync;
  assign o_vsync        = r_vsync;
  assign o_active       = r_active;
  assign o_x            = r_x;
  assign o_y            = r_y;
  assign o_lineStart    = r_lineStart;
  assign o_frameStart   = r_frameStart;
  assign o_scrollOffset = r_scrollOffset;

endmodule

// File: tb/tb_vga_scan_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_timing_gen
//
// Three instances share one clock:
//   dutD - default 640x480 timing, CLK_DIV=2; per-line statistics
//   dutS - tiny raster (H 2/2/8/2, V 1/1/4/1), scroll every 2 frames, wrap 4
//   dut1 - tiny raster with CLK_DIV=1, reset in the middle of a frame
// Expected per-line / per-frame / per-strobe records are queued by the
// stimulus; monitors pop and compare when the matching strobe appears.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_scan_timing_gen;

  localparam int W = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstA = 1'b1;
  logic rst1 = 1'b1;
  logic enD = 1'b1;
  logic enS = 1'b1;
  logic en1 = 1'b1;
  logic scrollEnD = 1'b1;
  logic scrollEnS = 1'b1;
  logic scrollEn1 = 1'b1;

  logic pixD, hsD, vsD, actD, lsD, fsD;
  logic [W-1:0] xD, yD, offD;
  logic pixS, hsS, vsS, actS, lsS, fsS;
  logic [W-1:0] xS, yS, offS;
  logic pix1, hs1, vs1, act1, ls1, fs1;
  logic [W-1:0] x1, y1, off1;

  vga_scan_timing_gen dutD (
    .i_clk(clk), .i_rst(rstA), .i_enable(enD), .i_scrollEn(scrollEnD),
    .o_pixCe(pixD), .o_hsync(hsD), .o_vsync(vsD), .o_active(actD),
    .o_x(xD), .o_y(yD), .o_lineStart(lsD), .o_frameStart(fsD),
    .o_scrollOffset(offD)
  );

  vga_scan_timing_gen #(
    .CLK_DIV(2), .H_SYNC(2), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
    .SCROLL_FRAMES(2), .SCROLL_MAX(4)
  ) dutS (
    .i_clk(clk), .i_rst(rstA), .i_enable(enS), .i_scrollEn(scrollEnS),
    .o_pixCe(pixS), .o_hsync(hsS), .o_vsync(vsS), .o_active(actS),
    .o_x(xS), .o_y(yS), .o_lineStart(lsS), .o_frameStart(fsS),
    .o_scrollOffset(offS)
  );

  vga_scan_timing_gen #(
    .CLK_DIV(1), .H_SYNC(2), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
    .SCROLL_FRAMES(1), .SCROLL_MAX(4)
  ) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_enable(en1), .i_scrollEn(scrollEn1),
    .o_pixCe(pix1), .o_hsync(hs1), .o_vsync(vs1), .o_active(act1),
    .o_x(x1), .o_y(y1), .o_lineStart(ls1), .o_frameStart(fs1),
    .o_scrollOffset(off1)
  );

  int nVectors = 0;
  int nMiscompares = 0;

  // One comparison: counts it, and reports a miscompare on its own line.
  task automatic checkOutput(input string name, input int actual, input int required);
    nVectors++;
    if (actual != required) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  // All outputs must sit at their reset values (syncs idle high).
  task automatic checkResetState(input string tag, input logic pix, input logic hs,
                                 input logic vs, input logic act, input logic ls,
                                 input logic fs, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic [W-1:0] off);
    checkOutput({tag, " reset pixCe"}, int'(pix), 0);
    checkOutput({tag, " reset hsync"}, int'(hs), 1);
    checkOutput({tag, " reset vsync"}, int'(vs), 1);
    checkOutput({tag, " reset active"}, int'(act), 0);
    checkOutput({tag, " reset lineStart"}, int'(ls), 0);
    checkOutput({tag, " reset frameStart"}, int'(fs), 0);
    checkOutput({tag, " reset x"}, int'(x), 0);
    checkOutput({tag, " reset y"}, int'(y), 0);
    checkOutput({tag, " reset scrollOffset"}, int'(off), 0);
  endtask

  // ---------------- dutD: per-line scoreboard ----------------
  typedef struct {
    int period; int hsLow; int vsLow; int actCnt; int firstOff; int firstX;
    int lastX; int rowY; int pixCnt; int fsCnt; int freezeErr; int jumpErr;
  } lineRec_t;

  lineRec_t lineExp[$];
  lineRec_t curLine;
  bit haveLine = 1'b0;
  bit doneD = 1'b0;
  int lineIdx = 0;
  int lineStartsD = 0;
  logic [W-1:0] prevXD = '0;
  logic [W-1:0] prevOffD = '0;
  logic prevHsD = 1'b1;
  logic prevActD = 1'b0;
  logic enAtEdgeD = 1'b1;

  function automatic lineRec_t freshLine();
    lineRec_t r;
    r.period = 0; r.hsLow = 0; r.vsLow = 0; r.actCnt = 0;
    r.firstOff = -1; r.firstX = -1; r.lastX = -1; r.rowY = -1;
    r.pixCnt = 0; r.fsCnt = 0; r.freezeErr = 0; r.jumpErr = 0;
    return r;
  endfunction

  // Hand-computed line expectations for the default 800x521 raster:
  // hsync low 96 px = 192 clks, visible from pixel 144 = clk 288, 1280 clks,
  // vsync low on lines 0/1, visible rows from line 31. Line 33 is held for
  // 37 clks inside its visible part, stretching period and active by 37.
  function automatic lineRec_t lineExpect(input int i);
    lineRec_t r;
    r = freshLine();
    r.period = (i == 33) ? 1637 : 1600;
    r.hsLow  = 192;
    r.vsLow  = (i < 2) ? 1600 : 0;
    r.pixCnt = 800;
    r.fsCnt  = (i == 0) ? 1 : 0;
    if (i >= 31) begin
      r.actCnt   = (i == 33) ? 1317 : 1280;
      r.firstOff = 288;
      r.firstX   = 0;
      r.lastX    = 639;
      r.rowY     = i - 31;
    end
    return r;
  endfunction

  task automatic scoreLine(input lineRec_t got);
    lineRec_t e;
    string t;
    if (lineExp.size() == 0) begin
      doneD = 1'b1;
      return;
    end
    e = lineExp.pop_front();
    t = $sformatf("line%0d", lineIdx);
    checkOutput({t, " period"}, got.period, e.period);
    checkOutput({t, " hsyncLow"}, got.hsLow, e.hsLow);
    checkOutput({t, " vsyncLow"}, got.vsLow, e.vsLow);
    checkOutput({t, " activeClks"}, got.actCnt, e.actCnt);
    checkOutput({t, " firstActiveOffset"}, got.firstOff, e.firstOff);
    checkOutput({t, " firstX"}, got.firstX, e.firstX);
    checkOutput({t, " lastX"}, got.lastX, e.lastX);
    checkOutput({t, " rowY"}, got.rowY, e.rowY);
    checkOutput({t, " pixCeCount"}, got.pixCnt, e.pixCnt);
    checkOutput({t, " frameStarts"}, got.fsCnt, e.fsCnt);
    checkOutput({t, " freezeViolations"}, got.freezeErr, e.freezeErr);
    checkOutput({t, " xJumps"}, got.jumpErr, e.jumpErr);
    lineIdx++;
    if (lineExp.size() == 0) doneD = 1'b1;
  endtask

  // Enable as the DUT saw it on the last rising edge.
  always @(posedge clk) enAtEdgeD <= enD;

  // Line monitor: a line runs from one lineStart to the next.
  always @(negedge clk) begin
    if (rstA) begin
      haveLine = 1'b0;
    end else if (!doneD) begin
      if (lsD) begin
        lineStartsD++;
        if (haveLine) scoreLine(curLine);
        curLine = freshLine();
        haveLine = 1'b1;
      end
      if (haveLine && !doneD) begin
        curLine.period += 1;
        if (!hsD) curLine.hsLow += 1;
        if (!vsD) curLine.vsLow += 1;
        if (pixD) curLine.pixCnt += 1;
        if (fsD) curLine.fsCnt += 1;
        if (actD) begin
          curLine.actCnt += 1;
          if (curLine.firstOff < 0) begin
            curLine.firstOff = curLine.period - 1;
            curLine.firstX = int'(xD);
            curLine.rowY = int'(yD);
          end
          curLine.lastX = int'(xD);
          if (prevActD && xD != prevXD && xD != prevXD + W'(1)) curLine.jumpErr += 1;
        end
        if (!enD && pixD) curLine.freezeErr += 1;
        if (!enAtEdgeD && (xD != prevXD || hsD != prevHsD || actD != prevActD ||
                           offD != prevOffD || lsD || fsD)) curLine.freezeErr += 1;
      end
    end
    prevXD = xD;
    prevOffD = offD;
    prevHsD = hsD;
    prevActD = actD;
  end

  // ---------------- dutS: per-frame scoreboard ----------------
  typedef struct {
    int period; int vsLow; int actCnt; int lastX; int lastY; int offset;
  } frameRec_t;

  frameRec_t frameExp[$];
  frameRec_t curFrame;
  bit haveFrame = 1'b0;
  bit doneS = 1'b0;
  int fsCountS = 0;
  int frameIdx = 0;

  task automatic scoreFrame(input frameRec_t got);
    frameRec_t e;
    string t;
    if (frameExp.size() == 0) begin
      doneS = 1'b1;
      return;
    end
    e = frameExp.pop_front();
    t = $sformatf("frame%0d", frameIdx);
    checkOutput({t, " period"}, got.period, e.period);
    checkOutput({t, " vsyncLow"}, got.vsLow, e.vsLow);
    checkOutput({t, " activeClks"}, got.actCnt, e.actCnt);
    checkOutput({t, " lastX"}, got.lastX, e.lastX);
    checkOutput({t, " lastY"}, got.lastY, e.lastY);
    checkOutput({t, " scrollOffset"}, got.offset, e.offset);
    frameIdx++;
    if (frameExp.size() == 0) doneS = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rstA && !doneS) begin
      if (fsS) begin
        fsCountS++;
        if (haveFrame) scoreFrame(curFrame);
        curFrame.period = 0;
        curFrame.vsLow = 0;
        curFrame.actCnt = 0;
        curFrame.lastX = -1;
        curFrame.lastY = -1;
        curFrame.offset = int'(offS);
        haveFrame = 1'b1;
      end
      if (haveFrame && !doneS) begin
        curFrame.period += 1;
        if (!vsS) curFrame.vsLow += 1;
        if (actS) begin
          curFrame.actCnt += 1;
          curFrame.lastX = int'(xS);
          curFrame.lastY = int'(yS);
        end
      end
    end
  end

  // ---------------- dut1: strobes after a mid-frame reset ----------------
  typedef struct { int t; int off; } fsRec_t;

  fsRec_t fsExp1[$];
  fsRec_t fsGot1;
  bit arm1 = 1'b0;
  bit done1 = 1'b0;
  bit gotAct1 = 1'b0;
  int cnt1 = 0;
  int pixErr1 = 0;

  always @(negedge clk) begin
    if (rst1) begin
      cnt1 = 0;
    end else if (arm1 && !done1) begin
      cnt1++;
      if (!pix1) pixErr1++;
      if (fs1) begin
        if (fsExp1.size() > 0) begin
          fsGot1 = fsExp1.pop_front();
          checkOutput("dut1 frameStart time", cnt1, fsGot1.t);
          checkOutput("dut1 scrollOffset", int'(off1), fsGot1.off);
        end else begin
          checkOutput("dut1 unexpected frameStart", cnt1, 0);
        end
      end
      if (act1 && !gotAct1) begin
        gotAct1 = 1'b1;
        checkOutput("dut1 firstActive time", cnt1, 34);
        checkOutput("dut1 firstActive x", int'(x1), 0);
        checkOutput("dut1 firstActive y", int'(y1), 0);
      end
      if (cnt1 == 250) begin
        checkOutput("dut1 pixCe gaps", pixErr1, 0);
        checkOutput("dut1 frameStarts missing", fsExp1.size(), 0);
        checkOutput("dut1 saw active", int'(gotAct1), 1);
        done1 = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic applyStimulus();
    int budget;
    int offSeq[16] = '{0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 1, 1, 1, 1, 2};
    frameRec_t fr;
    fsRec_t f1;

    for (int i = 0; i < 35; i++) lineExp.push_back(lineExpect(i));
    for (int i = 0; i < 16; i++) begin
      fr.period = 196; fr.vsLow = 28; fr.actCnt = 64;
      fr.lastX = 7; fr.lastY = 3; fr.offset = offSeq[i];
      frameExp.push_back(fr);
    end
    for (int i = 0; i < 3; i++) begin
      f1.t = 2 + 98 * i;
      f1.off = i + 1;
      fsExp1.push_back(f1);
    end

    repeat (3) @(posedge clk);
    #1;
    checkResetState("dutD", pixD, hsD, vsD, actD, lsD, fsD, xD, yD, offD);
    checkResetState("dutS", pixS, hsS, vsS, actS, lsS, fsS, xS, yS, offS);
    rstA = 1'b0;
    rst1 = 1'b0;

    repeat (150) @(posedge clk);
    #1;
    rst1 = 1'b1;
    arm1 = 1'b1;
    @(posedge clk);
    #1;
    checkResetState("dut1", pix1, hs1, vs1, act1, ls1, fs1, x1, y1, off1);
    @(posedge clk);
    #1;
    rst1 = 1'b0;

    budget = 0;
    while (fsCountS < 11 && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    checkOutput("wait dutS frame 10", fsCountS, 11);
    #1;
    scrollEnS = 1'b0;

    budget = 0;
    while (fsCountS < 14 && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    checkOutput("wait dutS frame 13", fsCountS, 14);
    #1;
    scrollEnS = 1'b1;

    budget = 0;
    while (lineStartsD < 34 && budget < 60000) begin
      @(posedge clk);
      budget++;
    end
    checkOutput("wait dutD line 33", lineStartsD, 34);
    repeat (700) @(posedge clk);
    #1;
    enD = 1'b0;
    repeat (37) @(posedge clk);
    #1;
    enD = 1'b1;

    budget = 0;
    while (!(doneD && doneS && done1) && budget < 10000) begin
      @(posedge clk);
      budget++;
    end
    checkOutput("dutD lines outstanding", lineExp.size(), 0);
    checkOutput("dutS frames outstanding", frameExp.size(), 0);
    checkOutput("dut1 checks finished", int'(done1), 1);
  endtask

  initial begin
    applyStimulus();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
